// File: rtl/crypt_pkg.sv
// crypt_pkg: shared state/key types, byte-lane indices and key rotation helpers.
package crypt_pkg;
  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;
  // Byte-lane index into a state word; lane 15 is [127:120].
  localparam int W0 = 15, W1 = 14, W2 = 13, W3 = 12;
  localparam int X0 = 11, X1 = 10, X2 = 9,  X3 = 8;
  localparam int Y0 = 7,  Y1 = 6,  Y2 = 5,  Y3 = 4;
  localparam int Z0 = 3,  Z1 = 2,  Z2 = 1,  Z3 = 0;
  function automatic key_t rotl2(input key_t k);
    return {k[125:0], k[127:126]};
  endfunction
  function automatic logic [15:0] byte_parity(input state_t s);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^s[8*i +: 8];
    return p;
  endfunction
endpackage

// File: rtl/stage6_out_fifo.sv
// stage6_out_fifo: 2-entry valid/ready queue with a registered head.
module stage6_out_fifo #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic         o_full
);
  logic [W-1:0] r_head, r_tail;
  logic [1:0]   r_cnt;
  assign o_dout  = r_head;
  assign o_valid = r_cnt != 2'd0;
  assign o_full  = r_cnt == 2'd2;
  // Head is only rewritten on a real transfer so it holds while full or empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else if (i_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && i_pop))) begin
      r_head <= i_din;
      r_cnt  <= 2'd1;
    end else if (i_push) begin
      r_tail <= i_din;
      r_cnt  <= 2'd2;
    end else if (i_pop) begin
      r_head <= r_cnt == 2'd2 ? r_tail : r_head;
      r_cnt  <= r_cnt - 2'd1;
    end
  end
endmodule

// File: rtl/stage6_key_mix.sv
// stage6_key_mix: XORs Stage5 state with the round key and queues it for downstream.
// Define STAGE6_PARITY_EN to add per-byte parity output out_parity.
module stage6_key_mix
  import crypt_pkg::*;
#(
  parameter int ROUNDS = 8,
  parameter int CNT_W  = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic             key_load,
  input  logic [127:0]     key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             out_last,
`ifdef STAGE6_PARITY_EN
  output logic [15:0]      out_parity,
`endif
  output logic             k0,
  output logic             k1,
  output logic [CNT_W-1:0] round_idx
);
`ifdef STAGE6_PARITY_EN
  localparam int PW = 145;
`else
  localparam int PW = 129;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);
  key_t             r_key, r_master;
  logic [CNT_W-1:0] r_round;
  logic             w_push, w_pop, w_full, w_last;
  state_t           w_mix;
  logic [PW-1:0]    w_din, w_dout;
  assign w_mix     = in_state ^ r_key;
  assign w_last    = r_round == LAST;
  assign in_ready  = reset & Enable & ~key_load & ~w_full;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready & Enable;
  assign k0        = r_key[0];
  assign k1        = r_key[1];
  assign round_idx = r_round;
`ifdef STAGE6_PARITY_EN
  assign w_din = {w_mix, w_last, byte_parity(w_mix)};
  assign {out_state, out_last, out_parity} = w_dout;
`else
  assign w_din = {w_mix, w_last};
  assign {out_state, out_last} = w_dout;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key    <= '0;
      r_master <= '0;
      r_round  <= '0;
    end else if (Enable && key_load) begin
      r_key    <= key_in;
      r_master <= key_in;
      r_round  <= '0;
    end else if (w_push) begin
      r_key    <= w_last ? r_master : rotl2(r_key);
      r_round  <= w_last ? '0 : r_round + CNT_W'(1);
    end
  end
  stage6_out_fifo #(.W(PW)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (w_din),
    .o_dout (w_dout),
    .o_valid(out_valid),
    .o_full (w_full)
  );
endmodule
